tdm_demux_1to4: RTL and testbench
=================================

Name: tdm_demux_1to4

Overview:
- Receiving end of the 4:1 mux path: rebuilds four parallel channels from a time-division-multiplexed stream.
- The upstream 4:1 mux cycles its select through a, b, c, d. This block tracks the slot, captures each beat into the matching channel, and presents all four channels together once per frame.
- It hunts for frame alignment, flags sync errors, and drives slot-select outputs with the same encoding as the mux, so the pair can run in loopback.

Parameters:
- WIDTH, 1, bit width of each channel sample and of the serial input.
- HOLD_ON_ERR, 1, 1 = keep the last good frame on the outputs after a sync error; 0 = clear the outputs to zero on a sync error.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  multiplexed sample stream.
- din_valid  input  1  din holds a valid beat this cycle.
- frame_start  input  1  qualified by din_valid; marks the current beat as slot 0 (channel a).
- a  output  WIDTH  registered channel 0 (select 00).
- b  output  WIDTH  registered channel 1 (select 01).
- c  output  WIDTH  registered channel 2 (select 10).
- d  output  WIDTH  registered channel 3 (select 11).
- out_valid  output  1  one-cycle pulse when a..d are updated with a complete frame.
- s1  output  1  LSB of the expected slot for the next beat (same meaning as mux select1).
- s2  output  1  MSB of the expected slot for the next beat (same meaning as mux select2).
- locked  output  1  high while in RUN state.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (async, rst=1):
  - a, b, c, d = 0; out_valid = 0; sync_err = 0; locked = 0; s1 = s2 = 0.
  - Slot counter = 0; shadow registers = 0; state = HUNT.
- Slot encoding is {s2,s1}: 00→a, 01→b, 10→c, 11→d.
- States: HUNT, RUN.
- HUNT:
  - Beats with din_valid=1 and frame_start=0 are discarded.
  - A beat with din_valid=1 and frame_start=1 captures din into shadow slot 0, sets the slot counter to 1, and moves to RUN.
  - locked goes high in the cycle after that capture.
- RUN, each beat with din_valid=1:
  - din is written into the shadow register at the current slot, and the counter increments mod 4.
  - {s2,s1} always shows the counter value, i.e. the slot the next beat fills.
- Frame completion:
  - The beat that fills slot 3 copies shadow slots 0-2 plus the current din into a..d, all in the same edge.
  - out_valid pulses in the cycle after that beat. Latency from the slot-3 beat to updated outputs is 1 clk.
  - a..d hold their values between frames.
- Cycles with din_valid=0: no state change. Gaps of any length between beats are allowed.
- frame_start with din_valid=0 is ignored.
- Normal wrap, RUN with counter = 0 and frame_start=1: normal slot-0 capture, no error.
- Sync error, RUN with counter != 0 and frame_start=1:
  - sync_err pulses for one cycle.
  - The partial frame is dropped and out_valid does not pulse.
  - The beat is taken as a new slot 0 and the counter goes to 1. State stays RUN and locked stays 1.
  - If HOLD_ON_ERR=0, a..d are cleared to 0 in the same edge.
- Missing frame_start, RUN with counter = 0 and frame_start=0:
  - sync_err pulses and the state returns to HUNT; the beat is discarded.
  - locked falls and the counter resets to 0.
  - If HOLD_ON_ERR=0, a..d are cleared to 0.
- Reset mid-frame: takes effect immediately. The partial frame is lost and no out_valid is issued.
- Simultaneous frame completion and error cannot occur, because each beat has a single slot.

Test Plan:
- Reset, then one frame 1,0,1,1 (WIDTH=1) with frame_start on the first beat → out_valid pulses 1 clk after beat 4; a=1, b=0, c=1, d=1; locked=1; {s2,s1} reads 01,10,11,00 after the beats.
- Two back-to-back frames (0,1,0,0) then (1,1,1,1), with frame_start each time, no gaps → two out_valid pulses 4 clks apart; outputs are 0100 then 1111; sync_err stays 0.
- Same frame with din_valid=0 gaps of 3 cycles between beats → same outputs as the gap-free case; the counter does not advance on gaps.
- frame_start asserted on beat 3 of a frame → sync_err pulses; no out_valid; the following 4 beats (0,0,1,1) give a=0, b=0, c=1, d=1.
- After a frame, a beat with frame_start=0 at slot 0 → sync_err pulses, locked=0, state HUNT; later beats are ignored until frame_start; with HOLD_ON_ERR=0, a..d = 0.
- Assert rst after 2 beats of a frame → all outputs 0 immediately; no out_valid; the next frame_start-aligned frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer: hunts for frame alignment on frame_start, collects four
// beats per frame and presents them together on a..d with a one-cycle out_valid.
module tdm_demux_1to4 #(
  parameter int WIDTH       = 1,
  parameter bit HOLD_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             s1,
  output logic             s2,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_c;

  // slot always names the position the next beat will fill
  assign {s2, s1} = slot;
  assign locked   = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= 2'd0;
      sh_a      <= '0;
      sh_b      <= '0;
      sh_c      <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_start) begin
              sh_a  <= din;
              slot  <= 2'd1;
              state <= RUN;
            end
          end
          default: begin
            if (frame_start) begin
              // early frame_start restarts the frame on this beat
              if (slot != 2'd0) begin
                sync_err <= 1'b1;
                if (!HOLD_ON_ERR) begin
                  a <= '0;
                  b <= '0;
                  c <= '0;
                  d <= '0;
                end
              end
              sh_a <= din;
              slot <= 2'd1;
            end else if (slot == 2'd0) begin
              // frame boundary without frame_start: alignment lost
              sync_err <= 1'b1;
              state    <= HUNT;
              slot     <= 2'd0;
              if (!HOLD_ON_ERR) begin
                a <= '0;
                b <= '0;
                c <= '0;
                d <= '0;
              end
            end else begin
              case (slot)
                2'd1:    sh_b <= din;
                2'd2:    sh_c <= din;
                default: begin
                  a         <= sh_a;
                  b         <= sh_b;
                  c         <= sh_c;
                  d         <= din;
                  out_valid <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4: two instances (hold / clear on error)
// share one stimulus stream and are checked against a frame-level model.
module tb_tdm_demux_1to4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_start;

  logic [W-1:0] oa [2];
  logic [W-1:0] ob [2];
  logic [W-1:0] oc [2];
  logic [W-1:0] od [2];
  logic         ov [2];
  logic         s1 [2];
  logic         s2 [2];
  logic         lk_o [2];
  logic         se [2];

  always #5 clk = ~clk;

  tdm_demux_1to4 #(.WIDTH(W), .HOLD_ON_ERR(1'b1)) dut_hold (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a(oa[0]), .b(ob[0]), .c(oc[0]), .d(od[0]), .out_valid(ov[0]),
    .s1(s1[0]), .s2(s2[0]), .locked(lk_o[0]), .sync_err(se[0]));

  tdm_demux_1to4 #(.WIDTH(W), .HOLD_ON_ERR(1'b0)) dut_clr (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a(oa[1]), .b(ob[1]), .c(oc[1]), .d(od[1]), .out_valid(ov[1]),
    .s1(s1[1]), .s2(s2[1]), .locked(lk_o[1]), .sync_err(se[1]));

  // reference model: a list of collected beats per instance
  bit             m_lk [2];
  int             m_n [2];
  logic [W-1:0]   m_part [2][3];
  logic [4*W-1:0] m_out [2];
  bit             m_ov [2];
  bit             m_se [2];

  // expected DUT view for the current cycle
  bit             e_lk [2];
  int             e_n [2];
  logic [4*W-1:0] e_out [2];
  bit             e_ov [2];
  bit             e_se [2];

  logic [4*W-1:0] fq0 [$];
  logic [4*W-1:0] fq1 [$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_lk[i]  = 0;
      m_n[i]   = 0;
      m_out[i] = '0;
      m_ov[i]  = 0;
      m_se[i]  = 0;
      for (int k = 0; k < 3; k++) m_part[i][k] = '0;
    end
  endtask

  task automatic m_snap();
    for (int i = 0; i < 2; i++) begin
      e_lk[i]  = m_lk[i];
      e_n[i]   = m_n[i];
      e_out[i] = m_out[i];
      e_ov[i]  = m_ov[i];
      e_se[i]  = m_se[i];
      m_ov[i]  = 0;
      m_se[i]  = 0;
    end
  endtask

  task automatic m_beat(input int i, input logic [W-1:0] dv, input bit fs);
    bit hold;
    logic [4*W-1:0] fr;
    hold = (i == 0);
    if (!m_lk[i]) begin
      if (fs) begin
        m_part[i][0] = dv;
        m_n[i]       = 1;
        m_lk[i]      = 1;
      end
    end else if (fs) begin
      if (m_n[i] != 0) begin
        m_se[i] = 1;
        if (!hold) m_out[i] = '0;
      end
      m_part[i][0] = dv;
      m_n[i]       = 1;
    end else if (m_n[i] == 0) begin
      m_se[i] = 1;
      m_lk[i] = 0;
      if (!hold) m_out[i] = '0;
    end else if (m_n[i] == 3) begin
      fr       = {m_part[i][0], m_part[i][1], m_part[i][2], dv};
      m_out[i] = fr;
      m_ov[i]  = 1;
      m_n[i]   = 0;
      if (i == 0) fq0.push_back(fr);
      else        fq1.push_back(fr);
    end else begin
      m_part[i][m_n[i]] = dv;
      m_n[i]            = m_n[i] + 1;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [W-1:0] dv, input bit fs);
    @(posedge clk);
    #1;
    if (r) begin
      rst = 1'b1;
      m_reset();
    end else begin
      rst = 1'b0;
    end
    m_snap();
    din_valid   = v;
    din         = dv;
    frame_start = fs;
    if (v && !r) begin
      m_beat(0, dv, fs);
      m_beat(1, dv, fs);
    end
  endtask

  task automatic beat(input logic [W-1:0] dv, input bit fs);
    step(0, 1, dv, fs);
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, W'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    idle(1);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
  endtask

  always @(negedge clk) begin
    logic [4*W-1:0] fr;
    for (int i = 0; i < 2; i++) begin
      chk("locked", i, 64'(lk_o[i]), 64'(e_lk[i]));
      chk("slot", i, 64'({s2[i], s1[i]}), 64'(e_n[i]));
      chk("outputs", i, 64'({oa[i], ob[i], oc[i], od[i]}), 64'(e_out[i]));
      chk("out_valid", i, 64'(ov[i]), 64'(e_ov[i]));
      chk("sync_err", i, 64'(se[i]), 64'(e_se[i]));
      if (ov[i] === 1'b1) begin
        if ((i == 0 && fq0.size() == 0) || (i == 1 && fq1.size() == 0)) begin
          n_cmp++;
          n_mis++;
          $display("FAIL frame dut%0d: got out_valid with %0h expected no frame at %0t", i,
                   {oa[i], ob[i], oc[i], od[i]}, $time);
        end else begin
          fr = (i == 0) ? fq0.pop_front() : fq1.pop_front();
          chk("frame", i, 64'({oa[i], ob[i], oc[i], od[i]}), 64'(fr));
        end
      end
    end
  end

  initial begin
    bit v, fs, r;
    rst         = 1'b1;
    din         = '0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    m_reset();
    m_snap();
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // single frame 1,0,1,1
    beat(4'd1, 1); beat(4'd0, 0); beat(4'd1, 0); beat(4'd1, 0);
    idle(2);
    // back-to-back frames
    beat(4'd0, 1); beat(4'd1, 0); beat(4'd0, 0); beat(4'd0, 0);
    beat(4'd1, 1); beat(4'd1, 0); beat(4'd1, 0); beat(4'd1, 0);
    // gaps of 3 idle cycles between beats
    beat(4'd1, 1); idle(3); beat(4'd0, 0); idle(3); beat(4'd1, 0); idle(3); beat(4'd1, 0);
    idle(2);
    // early frame_start on beat 3
    beat(4'd9, 1); beat(4'd5, 0); beat(4'd0, 1); beat(4'd0, 0); beat(4'd1, 0); beat(4'd1, 0);
    beat(4'd0, 1); beat(4'd0, 0); beat(4'd1, 0); beat(4'd1, 0);
    idle(1);
    // missing frame_start at slot 0, then ignored beats while hunting
    beat(4'd7, 0); beat(4'd3, 0); beat(4'd2, 0); idle(1);
    beat(4'd6, 1); beat(4'd5, 0); beat(4'd4, 0); beat(4'd3, 0);
    // reset after two beats of a frame
    beat(4'd8, 1); beat(4'd2, 0);
    do_reset();
    beat(4'hA, 1); beat(4'hB, 0); beat(4'hC, 0); beat(4'hD, 0);
    idle(2);

    for (int t = 0; t < 2000; t++) begin
      r = ($urandom_range(0, 299) == 0);
      if (r) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 9) < 7);
        if (!v)                          fs = 1'($urandom);
        else if (!m_lk[0] || m_n[0] == 0) fs = ($urandom_range(0, 7) != 0);
        else                             fs = ($urandom_range(0, 14) == 0);
        step(0, v, W'($urandom), fs);
      end
    end
    idle(3);

    chk("pending_frames", 0, 64'(fq0.size()), 64'd0);
    chk("pending_frames", 1, 64'(fq1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
